// File: rtl/aes_ctr_seq_if.sv
// Register bus between a host and the AES-CTR sequencer.
// There is no separate request strobe: any cycle with write=1 is a write.
// rdata and error are combinational replies to the current addr/write/wdata.
interface aes_ctr_seq_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;
    logic                  error;

    // Sequencer side
    modport in  (input addr, write, wdata, output rdata, ready, error);
    // Host side
    modport out (output addr, write, wdata, input rdata, ready, error);
endinterface

// File: rtl/aes_ctr_seq.sv
// AES counter-mode sequencer. It runs an external AES core over up to
// NUM_BLOCKS 128-bit plaintext blocks per start command, writes PT ^ keystream
// into the CT buffer and steps the 128-bit counter once per block.
module aes_ctr_seq #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 192,
    parameter int NUM_BLOCKS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [KEY_WIDTH-1:0] key_in,
    aes_ctr_seq_if.in            external_bus_io,
    output logic                 core_start_o,
    output logic [127:0]         core_ctr_o,
    output logic [KEY_WIDTH-1:0] core_key_o,
    input  logic [127:0]         core_ks_i,
    input  logic                 core_valid_i,
    output logic                 irq_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, DONE} state_e;

    state_e                       state_q, state_d;
    logic [127:0]                 ctr_q, ctr_d;
    logic [127:0]                 ks_q, ks_d;
    logic [NUM_BLOCKS-1:0][127:0] pt_q, pt_d;
    logic [NUM_BLOCKS-1:0][127:0] ct_q, ct_d;
    logic [4:0]                   nblk_q, nblk_d;
    logic [4:0]                   idx_q, idx_d;
    logic [4:0]                   bdone_q, bdone_d;
    logic [TW-1:0]                tmo_q, tmo_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic                         irq_en_q, irq_en_d;
    logic                         irq_q, irq_d;

    // Word j of a 128-bit value; j=0 is the most significant word.
    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] j);
        return v[32*(3-int'(j)) +: 32];
    endfunction

    // ---------------- bus decode ----------------
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  wr, wr_ok, bus_err, busy;
    logic [7:0]            widx;
    logic [3:0]            blk;
    logic [1:0]            wsel;
    logic                  blk_ok, is_ctrl, is_stat, is_ctr, is_pt, is_ct;
    logic                  unused_addr;

    assign addr        = external_bus_io.addr;
    assign wdata       = external_bus_io.wdata;
    assign wr          = external_bus_io.write;
    assign unused_addr = ^{addr[ADDR_WIDTH-1:10], addr[1:0]};

    assign busy    = (state_q != IDLE);
    assign widx    = addr[9:2];
    assign blk     = widx[5:2];
    assign wsel    = widx[1:0];
    assign blk_ok  = ({1'b0, blk} < 5'(NUM_BLOCKS));
    assign is_ctrl = (widx == 8'd0);
    assign is_stat = (widx == 8'd1);
    assign is_ctr  = (widx[7:2] == 6'd1);
    assign is_pt   = (widx[7:6] == 2'b01) && blk_ok;
    assign is_ct   = (widx[7:6] == 2'b10) && blk_ok;

    // A start, counter write or PT write while running is refused; the
    // whole write (including any abort/irq_en bits riding along) is dropped.
    assign bus_err = busy && wr && ((is_ctrl && wdata[0]) || is_ctr || is_pt);
    assign wr_ok   = wr && !bus_err;

    assign external_bus_io.ready = 1'b1;
    assign external_bus_io.error = bus_err;
    assign external_bus_io.rdata = rdata;

    // Combinational read mux; the key has no read path at all.
    always_comb begin
        rdata = '0;
        if (is_ctrl) begin
            rdata[2] = irq_en_q;
        end else if (is_stat) begin
            rdata[0]    = busy;
            rdata[1]    = done_q;
            rdata[2]    = err_q;
            rdata[12:8] = bdone_q;
        end else if (is_ctr) begin
            rdata = word_of(ctr_q, wsel);
        end else if (is_pt) begin
            for (int i = 0; i < NUM_BLOCKS; i++)
                if (blk == 4'(i)) rdata = word_of(pt_q[i], wsel);
        end else if (is_ct) begin
            for (int i = 0; i < NUM_BLOCKS; i++)
                if (blk == 4'(i)) rdata = word_of(ct_q[i], wsel);
        end
    end

    // Next-state: bus writes first, then FSM updates so FSM sets win over W1C.
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        ks_d     = ks_q;
        pt_d     = pt_q;
        ct_d     = ct_q;
        nblk_d   = nblk_q;
        idx_d    = idx_q;
        bdone_d  = bdone_q;
        tmo_d    = tmo_q;
        done_d   = done_q;
        err_d    = err_q;
        irq_en_d = irq_en_q;

        if (wr_ok) begin
            if (is_ctrl) irq_en_d = wdata[2];
            if (is_stat) begin
                if (wdata[1]) done_d = 1'b0;
                if (wdata[2]) err_d  = 1'b0;
            end
            if (is_ctr) ctr_d[32*(3-int'(wsel)) +: 32] = wdata;
            if (is_pt) begin
                for (int i = 0; i < NUM_BLOCKS; i++)
                    if (blk == 4'(i)) pt_d[i][32*(3-int'(wsel)) +: 32] = wdata;
            end
        end

        if (busy && wr_ok && is_ctrl && wdata[1]) begin
            // Abort: drop the block in flight, keep everything already stored.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (wr_ok && is_ctrl && wdata[0] && !wdata[1]) begin
                        if (wdata[12:8] != 5'd0 && wdata[12:8] <= 5'(NUM_BLOCKS)) begin
                            nblk_d  = wdata[12:8];
                            bdone_d = '0;
                            done_d  = 1'b0;
                            idx_d   = '0;
                            state_d = ISSUE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    tmo_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (core_valid_i) begin
                        ks_d    = core_ks_i;
                        state_d = STORE;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                STORE: begin
                    for (int i = 0; i < NUM_BLOCKS; i++)
                        if (idx_q == 5'(i)) ct_d[i] = pt_q[i] ^ ks_q;
                    ctr_d   = ctr_q + 128'd1;
                    bdone_d = bdone_q + 5'd1;
                    idx_d   = idx_q + 5'd1;
                    state_d = (idx_q + 5'd1 == nblk_q) ? DONE : ISSUE;
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // irq follows the next-cycle status so it rises and falls with the bits.
    assign irq_d = irq_en_d & (done_d | err_d);

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ctr_q    <= '0;
            ks_q     <= '0;
            pt_q     <= '0;
            ct_q     <= '0;
            nblk_q   <= '0;
            idx_q    <= '0;
            bdone_q  <= '0;
            tmo_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            ks_q     <= ks_d;
            pt_q     <= pt_d;
            ct_q     <= ct_d;
            nblk_q   <= nblk_d;
            idx_q    <= idx_d;
            bdone_q  <= bdone_d;
            tmo_q    <= tmo_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign core_start_o = (state_q == ISSUE);
    assign core_ctr_o   = ctr_q;
    assign core_key_o   = key_in;
    assign irq_o        = irq_q;
endmodule

// File: tb/tb_aes_ctr_seq.sv
// Bench for aes_ctr_seq: register tables, directed multi-cycle sequences and
// randomized commands against a block-level CTR model.
module tb_aes_ctr_seq;
    localparam int NB  = 4;
    localparam int KW  = 192;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] key_in, core_key;
    logic          core_start, core_valid, irq;
    logic [127:0]  core_ctr, core_ks;

    always #5 clk = ~clk;

    aes_ctr_seq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    aes_ctr_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .KEY_WIDTH(KW),
                  .NUM_BLOCKS(NB), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .key_in(key_in),
        .external_bus_io(bus),
        .core_start_o(core_start), .core_ctr_o(core_ctr), .core_key_o(core_key),
        .core_ks_i(core_ks), .core_valid_i(core_valid), .irq_o(irq));

    // Stub core: keystream = ctr ^ key[127:0], valid core_lat cycles after
    // start (0 = never, negative = random 1..4 per block).
    int           core_lat = 2;
    int           core_dly;
    logic [127:0] ksr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_dly <= 0;
            ksr      <= '0;
        end else if (core_start) begin
            core_dly <= (core_lat < 0) ? int'($urandom_range(4, 1)) : core_lat;
            ksr      <= core_ctr ^ core_key[127:0];
        end else if (core_dly != 0) begin
            core_dly <= core_dly - 1;
        end
    end
    assign core_valid = (core_dly == 1);
    assign core_ks    = ksr;

    // Record every start pulse and the counter presented with it.
    int           starts = 0;
    logic [127:0] ctr_seen[$];
    always @(negedge clk) if (core_start) begin
        starts++;
        ctr_seen.push_back(core_ctr);
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output logic e);
        @(negedge clk);
        bus.addr = a; bus.wdata = d; bus.write = 1'b1;
        #1 e = bus.error;
        @(posedge clk);
        #1 bus.write = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a; bus.write = 1'b0;
        #1 d = bus.rdata;
    endtask

    task automatic wr_blk(input logic [31:0] base, input logic [127:0] v);
        logic e;
        for (int j = 0; j < 4; j++) bus_wr(base + 32'(4*j), v[32*(3-j) +: 32], e);
    endtask

    task automatic rd_blk(input logic [31:0] base, output logic [127:0] v);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            bus_rd(base + 32'(4*j), w);
            v[32*(3-j) +: 32] = w;
        end
    endtask

    task automatic wait_idle(input string nm);
        logic [31:0] r;
        int n = 0;
        do begin bus_rd(32'h4, r); n++; end while (r[0] && n < 500);
        chk(nm, 128'(r[0]), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct { logic [31:0] addr; logic [31:0] exp; } rd_vec_t;
    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp_rd; logic exp_err; } wr_vec_t;

    rd_vec_t rst_tab[10];
    wr_vec_t wr_tab[9];

    initial begin
        logic [31:0]  r;
        logic [127:0] v, c0, p0;
        logic         e;
        int           n, s0;
        logic [127:0] m_ctr;
        logic [127:0] m_pt[NB];
        logic [127:0] m_ct[NB];

        // Register reads after reset: everything 0 (0x020 was the old key port).
        rst_tab = '{'{32'h000, 32'h0}, '{32'h004, 32'h0}, '{32'h010, 32'h0},
                    '{32'h014, 32'h0}, '{32'h018, 32'h0}, '{32'h01C, 32'h0},
                    '{32'h020, 32'h0}, '{32'h100, 32'h0}, '{32'h200, 32'h0},
                    '{32'h30C, 32'h0}};
        // Idle writes: {addr, wdata, expected readback, expected bus error}.
        wr_tab = '{'{32'h000, 32'h0000_0004, 32'h0000_0004, 1'b0},
                   '{32'h000, 32'h0000_0000, 32'h0000_0000, 1'b0},
                   '{32'h010, 32'h1234_5678, 32'h1234_5678, 1'b0},
                   '{32'h01C, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0},
                   '{32'h118, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0},
                   '{32'h204, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
                   '{32'h140, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
                   '{32'h004, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
                   '{32'h3F0, 32'h0000_0001, 32'h0000_0000, 1'b0}};

        bus.addr = '0; bus.wdata = '0; bus.write = 1'b0; key_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // ---- reset state and register map ----
        chk("rst_irq", 128'(irq), 128'd0);
        chk("rst_start", 128'(core_start), 128'd0);
        chk("rst_ctr_o", core_ctr, 128'd0);
        chk("ready", 128'(bus.ready), 128'd1);
        for (int i = 0; i < 10; i++) begin
            bus_rd(rst_tab[i].addr, r);
            chk($sformatf("rst_rd_%h", rst_tab[i].addr), 128'(r), 128'(rst_tab[i].exp));
        end
        for (int i = 0; i < 9; i++) begin
            bus_wr(wr_tab[i].addr, wr_tab[i].wdata, e);
            chk($sformatf("wr_err_%h", wr_tab[i].addr), 128'(e), 128'(wr_tab[i].exp_err));
            bus_rd(wr_tab[i].addr, r);
            chk($sformatf("wr_rd_%h", wr_tab[i].addr), 128'(r), 128'(wr_tab[i].exp_rd));
        end

        // ---- three blocks, core latency 2, ks = ctr ----
        core_lat = 2;
        wr_blk(32'h10, 128'd5);
        for (int i = 0; i < 3; i++) wr_blk(32'h100 + 32'(16*i), {16{8'hAA}});
        bus_wr(32'h0, 32'h0000_0301, e);
        chk("a_start_err", 128'(e), 128'd0);
        n = 0;
        do begin bus_rd(32'h4, r); if (r[0]) n++; end while (r[0] && n < 200);
        chk("a_busy_cycles", 128'(n), 128'd13);
        for (int i = 0; i < 3; i++) begin
            rd_blk(32'h200 + 32'(16*i), v);
            chk($sformatf("a_ct%0d", i), v, {16{8'hAA}} ^ 128'(5 + i));
        end
        rd_blk(32'h10, v);
        chk("a_ctr", v, 128'd8);
        bus_rd(32'h4, r);
        chk("a_status", 128'(r), 128'h302);
        chk("a_irq_off", 128'(irq), 128'd0);

        // ---- counter wrap across two blocks ----
        core_lat = 1;
        ctr_seen.delete();
        wr_blk(32'h10, '1);
        bus_wr(32'h0, 32'h0000_0201, e);
        wait_idle("w_idle");
        chk("w_nstarts", 128'(ctr_seen.size()), 128'd2);
        if (ctr_seen.size() == 2) begin
            chk("w_ctr0", ctr_seen[0], '1);
            chk("w_ctr1", ctr_seen[1], 128'd0);
        end
        rd_blk(32'h10, v);
        chk("w_ctr_final", v, 128'd1);

        // ---- timeout with irq enabled ----
        core_lat = 0;
        bus_wr(32'h0, 32'h0000_0105, e);
        @(posedge clk);  // entering WAIT
        n = 0;
        do begin bus_rd(32'h4, r); if (!r[2]) n++; end while (!r[2] && n < 200);
        chk("t_cycles", 128'(n), 128'(TMO));
        chk("t_status", 128'(r), 128'h4);
        chk("t_irq_on", 128'(irq), 128'd1);
        bus_wr(32'h4, 32'h4, e);
        chk("t_irq_off", 128'(irq), 128'd0);
        bus_rd(32'h4, r);
        chk("t_status_clr", 128'(r), 128'h0);
        bus_wr(32'h0, 32'h0, e);

        // ---- busy write protection and abort in block 2 ----
        core_lat = 3;
        c0 = 128'h100;
        p0 = rnd128();
        wr_blk(32'h10, c0);
        wr_blk(32'h100, p0);
        s0 = starts;
        bus_wr(32'h0, 32'h0000_0301, e);
        bus_wr(32'h100, 32'h1234_5678, e);
        chk("b_pt_err", 128'(e), 128'd1);
        bus_wr(32'h1C, 32'h1, e);
        chk("b_ctr_err", 128'(e), 128'd1);
        bus_wr(32'h0, 32'h0000_0301, e);
        chk("b_start_err", 128'(e), 128'd1);
        n = 0;
        do begin bus_rd(32'h4, r); n++; end while (r[12:8] != 5'd1 && n < 100);
        bus_wr(32'h0, 32'h2, e);
        chk("b_abort_err", 128'(e), 128'd0);
        bus_rd(32'h4, r);
        chk("b_status", 128'(r), 128'h100);
        chk("b_nstarts", 128'(starts - s0), 128'd2);
        rd_blk(32'h100, v);
        chk("b_pt0", v, p0);
        rd_blk(32'h10, v);
        chk("b_ctr", v, c0 + 128'd1);
        rd_blk(32'h200, v);
        chk("b_ct0", v, p0 ^ c0);

        // ---- illegal nblocks, start+abort in idle ----
        s0 = starts;
        bus_wr(32'h0, 32'h0000_0001, e);
        bus_rd(32'h4, r);
        chk("n0_status", 128'(r), 128'h104);
        bus_wr(32'h4, 32'h4, e);
        bus_wr(32'h0, 32'(((NB + 1) << 8) | 1), e);
        bus_rd(32'h4, r);
        chk("nbig_status", 128'(r), 128'h104);
        bus_wr(32'h4, 32'h4, e);
        bus_wr(32'h0, 32'(((NB) << 8) | 3), e);
        repeat (3) bus_rd(32'h4, r);
        chk("sa_status", 128'(r), 128'h100);
        chk("bad_nstarts", 128'(starts - s0), 128'd0);

        // ---- asynchronous reset in WAIT ----
        core_lat = 0;
        bus_wr(32'h0, 32'h0000_0105, e);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.addr = 32'h4;
        rst_n = 1'b0;
        #1;
        chk("r_status", 128'(bus.rdata), 128'd0);
        chk("r_start", 128'(core_start), 128'd0);
        chk("r_ctr_o", core_ctr, 128'd0);
        chk("r_irq", 128'(irq), 128'd0);
        bus.addr = 32'h200;
        #1 chk("r_ct0", 128'(bus.rdata), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rd_blk(32'h10, v);
        chk("r_ctr", v, 128'd0);
        rd_blk(32'h100, v);
        chk("r_pt0", v, 128'd0);
        bus_rd(32'h0, r);
        chk("r_ctrl", 128'(r), 128'd0);

        // ---- randomized commands vs CTR model ----
        core_lat = -1;
        m_ctr = '0;
        for (int i = 0; i < NB; i++) begin m_pt[i] = '0; m_ct[i] = '0; end
        for (int c = 0; c < 16; c++) begin
            logic ien;
            key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ien = 1'($urandom_range(1, 0));
            n = int'($urandom_range(NB, 1));
            for (int i = 0; i < NB; i++)
                if ($urandom_range(1, 0) == 1) begin
                    m_pt[i] = rnd128();
                    wr_blk(32'h100 + 32'(16*i), m_pt[i]);
                end
            if ($urandom_range(2, 0) == 0) begin
                m_ctr = rnd128();
                if ($urandom_range(1, 0) == 1)
                    m_ctr = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF - 32'($urandom_range(2, 0))};
                wr_blk(32'h10, m_ctr);
            end
            bus_wr(32'h0, {19'b0, 5'(n), 5'b0, ien, 1'b0, 1'b1}, e);
            wait_idle($sformatf("rnd%0d_idle", c));
            for (int i = 0; i < n; i++) begin
                m_ct[i] = m_pt[i] ^ m_ctr ^ key_in[127:0];
                m_ctr   = m_ctr + 128'd1;
            end
            for (int i = 0; i < NB; i++) begin
                rd_blk(32'h200 + 32'(16*i), v);
                chk($sformatf("rnd%0d_ct%0d", c, i), v, m_ct[i]);
            end
            rd_blk(32'h10, v);
            chk($sformatf("rnd%0d_ctr", c), v, m_ctr);
            bus_rd(32'h4, r);
            chk($sformatf("rnd%0d_status", c), 128'(r), 128'(32'h2 | (n << 8)));
            chk($sformatf("rnd%0d_irq", c), 128'(irq), 128'(ien));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", checks - fails, checks);
        $fatal(1);
    end
endmodule
